mem_stream_port: RTL
====================

# mem_stream_port

Initiator-side companion to the byte-addressable data memory: drives the memory's load/store port to bulk-load memory from a byte stream, or dump it back out as a byte stream. It sits between a host-facing byte link (bootloader or debug path) and the 4 KiB data memory, replacing file-based preload at run time. Word byte order matches the hex-image convention: the first stream byte of each word is the byte stored at `addr+3`.

## Interface
Parameters:
- `MEM_BYTES`, 4096, memory size in bytes; address width is 12.

Ports:
- `clk` in 1, the single clock; all logic is rising-edge.
- `rst` in 1, synchronous, active-high reset.
- `start` in 1, one-cycle request to begin a transfer; ignored while `busy`.
- `mode` in 1, sampled with `start`: 0 = load (stream→memory), 1 = dump (memory→stream).
- `base_addr` in 12, start byte address; bits [1:0] forced to 00.
- `word_count` in 11, words to transfer (0..1024).
- `s_valid` in 1, `s_data` in 8, `s_ready` out 1: load input stream.
- `m_valid` out 1, `m_data` out 8, `m_ready` in 1: dump output stream.
- `busy` out 1, high from the cycle after accepted `start` until `done`.
- `done` out 1, one-cycle completion pulse.
- `checksum` out 8, mod-256 sum of all bytes transferred in the current/last job.
- `mem_read` out 3, memory load code (111 = word, 000 = none).
- `mem_write` out 2, memory store code (11 = word, 00 = none).
- `mem_addr` out 12, byte address to memory.
- `mem_wdata` out 32, store data to memory.
- `mem_rdata` in 32, combinational load data from memory.

## Operation
- States: IDLE, LD_COLLECT, LD_WRITE, DP_READ, DP_SEND, FIN.
- IDLE: `start`=1 latches mode, `cur_addr` = {base_addr[11:2],2'b00}, `remaining` = word_count, clears checksum and byte index. `remaining`=0 → FIN; else mode 0 → LD_COLLECT, mode 1 → DP_READ.
- LD_COLLECT: `s_ready`=1. Each `s_valid&&s_ready` byte k (0..3) is written to word bits [31-8k:24-8k]; checksum += byte. After k=3 → LD_WRITE.
- LD_WRITE: `mem_write`=11, `mem_addr`=cur_addr, `mem_wdata`=assembled word, exactly one cycle. Then `cur_addr`+=4 (mod 4096, wraps 0xFFC→0x000), `remaining`-=1; 0 → FIN else LD_COLLECT.
- DP_READ: `mem_read`=111, `mem_addr`=cur_addr for one cycle; `mem_rdata` captured into shift register at the end of that cycle → DP_SEND.
- DP_SEND: `m_valid`=1, `m_data`=shift[31:24]; on `m_ready` shift left 8, checksum += byte; after 4th handshake advance address/count as in LD_WRITE; 0 → FIN else DP_READ.
- FIN: `done`=1 for one cycle → IDLE. `checksum` holds until next accepted `start`.
- `mem_read`, `mem_write` are 00/000 in every state other than DP_READ/LD_WRITE respectively; decoded from registered state only, never from `s_valid`/`m_ready`.
- `m_valid`, once high, stays high with stable `m_data` until `m_ready`.
- `start` while busy: no effect. `mode`/`base_addr`/`word_count` changes while busy: no effect.

## Timing
- Reset: state IDLE; `busy`, `done`, `s_ready`, `m_valid`, `checksum`, `m_data`, `mem_read`, `mem_write`, `mem_addr`, `mem_wdata` all 0. Reset mid-job aborts immediately with no further store; partial word discarded.
- Memory commits stores on the falling edge; `mem_write`/`mem_addr`/`mem_wdata` are stable for the whole LD_WRITE cycle.
- Load, full-rate input: 5 cycles per word (4 collect + 1 write). Dump, `m_ready` held high: 5 cycles per word (1 read + 4 send).
- `start` at edge N → `busy` at N+1; `word_count`=0 → `done` at N+1, `busy` stays 0.
- Last store/last send handshake at edge M → `done` high in cycle M+1, `busy` low from M+2.

## Test plan
- Load 2 words at 0x010, bytes 11 22 33 44 55 66 77 88 → mem[0x010..0x013]=44,33,22,11; mem[0x014..0x017]=88,77,66,55; exactly two `mem_write`=11 cycles; checksum=0x64; `done` once.
- Dump 2 words at 0x010 after above, `m_ready`=1 → m_data 11 22 33 44 55 66 77 88, 10 cycles from `busy` to last byte, checksum=0x64.
- Dump with `m_ready` toggling 1/0 each cycle → same byte order, `m_data` stable while stalled, no extra `mem_read` pulses.
- Load 2 words at base_addr 0xFFE → first store at 0xFFC, second at 0x000 (wrap).
- `word_count`=0 → `done` next cycle, no memory access; `start` during active job → ignored, output unchanged.
- Assert `rst` after 2 bytes of a load word → no store occurs, all outputs 0 next cycle, new job runs normally.

Source files
------------

// File: rtl/mem_stream_port.sv
// Purpose: byte-stream port that bulk-loads the 4 KiB data memory or dumps it back out.
// Latency: 5 cycles/word at full rate (load: 4 collect + 1 store; dump: 1 read + 4 send); done 1 cycle after last beat.
// Backpressure: s_ready only in LD_COLLECT; m_valid holds with stable m_data until m_ready.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   start, mode, base_addr,       job request (mode 0 = load stream->memory, 1 = dump memory->stream),
//   word_count                    sampled only while idle
//   s_valid, s_data, s_ready      load input byte stream
//   m_valid, m_data, m_ready      dump output byte stream
//   busy, done, checksum          job status; checksum is mod-256 sum of bytes moved by the current/last job
//   mem_read, mem_write,          memory load/store port (111 / 11 = word access, zero = idle)
//   mem_addr, mem_wdata, mem_rdata
//
// Byte order follows the hex-image convention: the first stream byte of a word
// lives at addr+3, i.e. it is word bits [31:24].

module mem_stream_port #(
    parameter int MEM_BYTES = 4096,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-2:0] word_count,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          m_valid,
    output logic [7:0]    m_data,
    input  logic          m_ready,
    output logic          busy,
    output logic          done,
    output logic [7:0]    checksum,
    output logic [2:0]    mem_read,
    output logic [1:0]    mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LD_COLLECT = 3'd1,
        S_LD_WRITE   = 3'd2,
        S_DP_READ    = 3'd3,
        S_DP_SEND    = 3'd4,
        S_FIN        = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [AW-1:0] r_addr;
    logic [AW-2:0] r_remaining;
    logic [1:0]    r_byte_idx;
    logic [31:0]   r_word;
    logic [31:0]   r_shift;
    logic [7:0]    r_checksum;
    logic          r_busy;

    logic          w_s_fire;
    logic          w_m_fire;
    logic          w_last_byte;
    logic          w_last_word;
    logic [AW-1:0] w_base_aligned;

    // Handshakes are qualified by registered state, never by the partner's signal alone.
    assign w_s_fire       = s_valid && (r_state == S_LD_COLLECT);
    assign w_m_fire       = m_ready && (r_state == S_DP_SEND);
    assign w_last_byte    = (r_byte_idx == 2'd3);
    assign w_last_word    = (r_remaining == AW'(1));
    // Jobs always start on a word boundary.
    assign w_base_aligned = base_addr & {{(AW-2){1'b1}}, 2'b00};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        w_next_state = S_FIN;
                    end else if (mode) begin
                        w_next_state = S_DP_READ;
                    end else begin
                        w_next_state = S_LD_COLLECT;
                    end
                end
            end
            S_LD_COLLECT: begin
                if (w_s_fire && w_last_byte) begin
                    w_next_state = S_LD_WRITE;
                end
            end
            S_LD_WRITE: begin
                w_next_state = w_last_word ? S_FIN : S_LD_COLLECT;
            end
            S_DP_READ: begin
                w_next_state = S_DP_SEND;
            end
            S_DP_SEND: begin
                if (w_m_fire && w_last_byte) begin
                    w_next_state = w_last_word ? S_FIN : S_DP_READ;
                end
            end
            S_FIN: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        m_data    = 8'h00;
        done      = 1'b0;
        mem_read  = 3'b000;
        mem_write = 2'b00;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        case (r_state)
            S_LD_COLLECT: begin
                s_ready = 1'b1;
            end
            S_LD_WRITE: begin
                mem_write = 2'b11;
                mem_addr  = r_addr;
                mem_wdata = r_word;
            end
            S_DP_READ: begin
                mem_read = 3'b111;
                mem_addr = r_addr;
            end
            S_DP_SEND: begin
                m_valid = 1'b1;
                m_data  = r_shift[31:24];
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy     = r_busy;
    assign checksum = r_checksum;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_byte_idx  <= 2'd0;
            r_word      <= 32'h0;
            r_shift     <= 32'h0;
            r_checksum  <= 8'h00;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= w_base_aligned;
                        r_remaining <= word_count;
                        r_byte_idx  <= 2'd0;
                        r_checksum  <= 8'h00;
                        // A zero-length job goes straight to FIN and never looks busy.
                        r_busy      <= (word_count != '0);
                    end
                end
                S_LD_COLLECT: begin
                    if (w_s_fire) begin
                        // Shifting in from the bottom leaves the first byte in [31:24].
                        r_word     <= {r_word[23:0], s_data};
                        r_checksum <= r_checksum + s_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                end
                S_LD_WRITE: begin
                    r_addr      <= r_addr + AW'(4);
                    r_remaining <= r_remaining - AW'(1);
                end
                S_DP_READ: begin
                    r_shift <= mem_rdata;
                end
                S_DP_SEND: begin
                    if (w_m_fire) begin
                        r_shift    <= {r_shift[23:0], 8'h00};
                        r_checksum <= r_checksum + r_shift[31:24];
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (w_last_byte) begin
                            r_addr      <= r_addr + AW'(4);
                            r_remaining <= r_remaining - AW'(1);
                        end
                    end
                end
                S_FIN: begin
                    // busy stays up through the done cycle and drops after it.
                    r_busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
